if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the RV32I core: owns the PC, issues one read at a time to
//  instruction memory and registers the returned word with its PC into the IF/ID slot.
//  The slot's if_instr drives the decoder and imm_gen directly. Supports a decode-side
//  stall (id_ready) and an EX-side redirect (branch/jump target) that flushes the slot.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  NOP       32'h0000_0013 instruction word held in if_instr while slot invalid (addi x0,x0,0)
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     asynchronous, active-high reset
//  imem_req       out  1     read request; accepted by memory in the same cycle
//  imem_addr      out  XLEN  read address (= pc, bits[1:0] always 0)
//  imem_rvalid    in   1     read data valid, >=1 cycle after accepted request
//  imem_rdata     in   XLEN  instruction word
//  redirect       in   1     taken branch/jump from EX: flush and refetch
//  redirect_pc    in   XLEN  new fetch target
//  id_ready       in   1     decode consumes slot this cycle when if_valid=1
//  if_valid       out  1     IF/ID slot holds a live instruction
//  if_instr       out  XLEN  instruction to decoder/imm_gen
//  if_pc          out  XLEN  PC of if_instr
// BEHAVIOUR
//  - Reset (async, any state): pc=RESET_PC, state=S_FETCH, if_valid=0, if_instr=NOP,
//    if_pc=0; imem_req=0 while rst high.
//  - States: S_FETCH (may issue), S_WAIT (one request outstanding), S_DROP (outstanding
//    request killed, response to be discarded). At most one request in flight.
//  - slot_free = !if_valid || id_ready.
//  - S_FETCH: imem_req = slot_free && !redirect (combinational), imem_addr=pc.
//    req issued -> S_WAIT. redirect -> pc=redirect_pc, stay S_FETCH, no request.
//  - S_WAIT, imem_rvalid=1, redirect=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1,
//    pc<=pc+4 (wraps mod 2^XLEN), -> S_FETCH.
//  - S_WAIT, imem_rvalid=1, redirect=1: data discarded, pc<=redirect_pc, -> S_FETCH.
//  - S_WAIT, imem_rvalid=0, redirect=1: pc<=redirect_pc, -> S_DROP.
//  - S_DROP: redirect updates pc again; on imem_rvalid data discarded, -> S_FETCH.
//  - Slot: if_valid && id_ready with no new load -> if_valid<=0, if_instr<=NOP.
//    Consume and load in the same cycle -> new word replaces old, if_valid stays 1.
//    Slot never overwritten while if_valid=1 && id_ready=0 (guaranteed by slot_free gate).
//  - redirect=1 forces if_valid<=0, if_instr<=NOP next cycle, overriding any load.
//  - redirect_pc[1:0] ignored (pc low bits forced 0); no misalign trap in this block.
//  - Throughput: 1 instr / 2 cycles with 1-cycle memory; latency req->slot = mem latency.
//  - imem_rvalid outside S_WAIT/S_DROP is ignored.
// TESTING
//  1 Reset then 1-cycle mem returning 0x00100013 @0, 0x00200093 @4 -> if_pc 0,4 in order,
//    if_instr matches, imem_addr sequence 0,4,8.
//  2 id_ready=0 for 5 cycles with slot full -> if_instr/if_pc stable, imem_req=0; release
//    -> next addr issued same cycle.
//  3 redirect to 0x0000_0100 while S_WAIT, rvalid 2 cycles later with 0xDEADBEEF ->
//    0xDEADBEEF never appears with if_valid=1; next imem_addr=0x100.
//  4 redirect coincident with rvalid -> data dropped, if_valid=0, next addr = redirect_pc.
//  5 RESET_PC=32'hFFFF_FFFC, fetch one -> next imem_addr=0x0000_0000 (wrap).
//  6 Assert rst mid-S_WAIT -> outputs at reset values same cycle; first addr = RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch stage: PC, single-outstanding imem read, IF/ID slot
module if_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [XLEN-1:0]   NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;

    logic            slot_free;
    logic            load;
    logic [XLEN-1:0] target_pc;

    assign slot_free = !if_valid_q || id_ready;
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
    // rst gates the request so memory never sees a fetch while the core is held in reset
    assign imem_req  = !rst && (state_q == S_FETCH) && slot_free && !redirect;
    assign imem_addr = pc_q;
    assign load      = (state_q == S_WAIT) && imem_rvalid && !redirect;

    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            pc_d = target_pc;
        end else if (load) begin
            pc_d = pc_q + XLEN'(4);
        end
        case (state_q)
            S_FETCH: if (imem_req) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)   state_d = S_FETCH;
                else if (redirect) state_d = S_DROP;
            end
            S_DROP:  if (imem_rvalid) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Redirect beats both load and consume: the slot is always flushed to NOP
    always_comb begin
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if (redirect) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP;
        end else if (load) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
        end else if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a program-order fetch model
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    int total = 0;
    int bad   = 0;

    // memory model: one tracked request, fixed or random latency
    bit          m_pend;
    logic [31:0] m_addr;
    int          m_wait;
    int          lat_fix;
    bit          force_en;
    logic [31:0] force_data;

    // program-order model: next PC decode must receive
    logic [31:0] exp_pc;
    int          consumed;
    logic [31:0] req_log[$];

    bit          p_hold, p_redir;
    logic [31:0] p_instr, p_pc;

    bit          s_req, s_valid;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0013;
        if (a == 32'h4) return 32'h0020_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit rv;
        @(negedge clk);
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        rv = m_pend && (m_wait == 0);
        if (rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = force_en ? force_data : memf(m_addr);
        end else if (!m_pend && $urandom_range(0, 4) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = if_valid;
        s_pc    = if_pc;
        if (!if_valid) chk("nop_when_empty", if_instr, NOP);
        chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        chk("no_stale_deadbeef", {31'b0, (if_valid && if_instr == 32'hDEAD_BEEF)}, 32'h0);
        if (p_redir) chk("flush_after_redirect", {31'b0, if_valid}, 32'h0);
        if (p_hold) begin
            chk("hold_valid", {31'b0, if_valid}, 32'h1);
            chk("hold_instr", if_instr, p_instr);
            chk("hold_pc", if_pc, p_pc);
        end
        if (imem_req) chk("one_in_flight", {31'b0, m_pend && !rv}, 32'h0);
        if (if_valid && id_ready) begin
            chk("consume_pc", if_pc, exp_pc);
            chk("consume_instr", if_instr, memf(if_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (redir) exp_pc = {rpc[31:2], 2'b00};
        p_hold  = if_valid && !id_ready && !redir;
        p_instr = if_instr;
        p_pc    = if_pc;
        p_redir = redir;
        if (rv) begin
            m_pend   = 1'b0;
            force_en = 1'b0;
        end else if (m_pend) begin
            m_wait--;
        end
        if (imem_req) begin
            m_pend = 1'b1;
            m_addr = imem_addr;
            m_wait = ((lat_fix > 0) ? lat_fix : $urandom_range(1, 3)) - 1;
            req_log.push_back(imem_addr);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        redirect    = 1'b0;
        id_ready    = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        m_pend   = 1'b0;
        force_en = 1'b0;
        exp_pc   = 32'h0;
        p_hold   = 1'b0;
        p_redir  = 1'b0;
        req_log.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        s_req = 1'b0;
        while (!s_req && n < 20) begin
            step(1'b1, 1'b0, 32'h0);
            n++;
        end
        chk({tag, "_req_timeout"}, {31'b0, s_req}, 32'h1);
    endtask

    initial begin
        int c0;
        int n;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0;
        lat_fix = 1; consumed = 0;

        // in-order fetch with 1-cycle memory
        do_reset();
        repeat (8) step(1'b1, 1'b0, 32'h0);
        chk("t1_req_count", {31'b0, (req_log.size() >= 3)}, 32'h1);
        if (req_log.size() >= 3) begin
            chk("t1_addr0", req_log[0], 32'h0);
            chk("t1_addr1", req_log[1], 32'h4);
            chk("t1_addr2", req_log[2], 32'h8);
        end
        chk("t1_consumed", {31'b0, (consumed >= 2)}, 32'h1);

        // decode stall holds the slot and suppresses fetch
        n = 0; s_valid = 1'b0;
        while (!s_valid && n < 20) begin step(1'b0, 1'b0, 32'h0); n++; end
        chk("t2_fill_timeout", {31'b0, s_valid}, 32'h1);
        repeat (5) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t2_req_stalled", {31'b0, s_req}, 32'h0);
        end
        step(1'b1, 1'b0, 32'h0);
        chk("t2_req_release", {31'b0, s_req}, 32'h1);
        chk("t2_addr_release", s_addr, s_pc + 32'd4);

        // redirect while waiting; late response must be dropped
        lat_fix = 3;
        wait_req("t3a");
        force_en = 1'b1; force_data = 32'hDEAD_BEEF;
        step(1'b1, 1'b1, 32'h0000_0100);
        wait_req("t3b");
        chk("t3_addr", s_addr, 32'h0000_0100);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // redirect coincident with rvalid; low target bits ignored
        lat_fix = 1;
        wait_req("t4a");
        step(1'b1, 1'b1, 32'h0000_0207);
        step(1'b1, 1'b0, 32'h0);
        chk("t4_slot_empty", {31'b0, s_valid}, 32'h0);
        if (!s_req) wait_req("t4b");
        chk("t4_addr", s_addr, 32'h0000_0204);

        // PC wrap at top of address space
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        wait_req("t5a");
        chk("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        wait_req("t5b");
        chk("t5_addr_wrap", s_addr, 32'h0);

        // reset while a request is outstanding
        lat_fix = 3;
        wait_req("t6a");
        step(1'b1, 1'b0, 32'h0);
        do_reset();
        wait_req("t6b");
        chk("t6_first_addr", s_addr, 32'h0);

        // random stall/redirect/latency mix
        lat_fix = 0;
        c0 = consumed;
        repeat (600) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 32'h0000_0FFF));
        end
        chk("rand_progress", {31'b0, ((consumed - c0) > 30)}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
